loop_controller: RTL and testbench
==================================

# loop_controller

Control-flow stage for the brainfuck CPU, placed between instruction decode and the datapath. Consumes the one-hot `operation` word from decode, forwards datapath ops (`> < + - . ,`) through a one-entry output register, and executes `[`/`]` itself. `[`/`]` execution uses a return-address stack, a skip-depth counter and a branch request to fetch. Brackets are never forwarded downstream.

## Interface
Parameters:
- `PC_WIDTH`, 12, instruction address width
- `STACK_DEPTH`, 16, max nested open loops (power of two)
- `SKIP_WIDTH`, 8, skip-depth counter width

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `op_in`  in  8  one-hot operation from decode; bit0 `>`, 1 `<`, 2 `+`, 3 `-`, 4 `.`, 5 `,`, 6 `[`, 7 `]`; all-zero = NOP
- `op_pc`  in  PC_WIDTH  address of `op_in`
- `op_valid`  in  1  `op_in`/`op_pc` valid
- `op_ack`  out  1  op consumed this cycle (transfer = `op_valid & op_ack`)
- `cell_zero`  in  1  current cell == 0, meaningful when `cell_zero_valid`
- `cell_zero_valid`  in  1  datapath has no ops in flight; `cell_zero` final
- `op_out`  out  8  forwarded datapath op (bits 6/7 always 0)
- `op_out_valid`  out  1  `op_out` valid
- `op_out_ack`  in  1  datapath accepts `op_out`
- `branch`  out  1  one-cycle redirect pulse to fetch
- `branch_target`  out  PC_WIDTH  redirect address, valid with `branch`
- `error`  out  1  sticky fault
- `loop_level`  out  log2(STACK_DEPTH)+1  current stack occupancy

## Operation
States: RUN, SKIP, ERR.
- RUN, datapath op or NOP: accept when `!op_out_valid | op_out_ack`. NOP is consumed and dropped. Otherwise the op loads `op_out` and sets `op_out_valid`.
- RUN, `[` or `]`: accept only when `cell_zero_valid & !op_out_valid & !branch`.
  - `[` with cell≠0: push `op_pc`.
  - `[` with cell=0: `skip_depth`←1, go to SKIP; no push.
  - `]` with cell≠0: `branch`←1, `branch_target`←top+1; stack unchanged.
  - `]` with cell=0: pop.
  - `]` with empty stack: go to ERR.
- SKIP: accept every valid op unconditionally; nothing is forwarded.
  - `[`: depth+1.
  - `]`: depth−1; on reaching 0, go to RUN.
  - Depth increment at all-ones: go to ERR.
- Push when stack full: go to ERR.
- ERR: `error`=1, `op_ack`=0, stack frozen. `op_out` drains normally. Only reset exits ERR.
- Ops whose bit 6 or 7 is set together with any other bit are malformed: go to ERR.
- Fetch/decode flush in the same cycle `branch`=1. `op_ack` is 0 during the branch cycle. The first op offered afterwards carries `op_pc == branch_target`.
- Reset values: state RUN, stack empty, `loop_level` 0, skip depth 0, `op_out` 0, `op_out_valid` 0, `branch` 0, `branch_target` 0, `error` 0.

## Timing
- Datapath op accepted at cycle N → `op_out_valid` at N+1. Sustained throughput is 1 op/cycle while `op_out_ack`=1.
- `op_out_valid` holds and `op_out` stays stable until `op_out_ack`.
- Bracket accepted at N:
  - Stack, `loop_level` and state update at N+1.
  - `branch` is high for cycle N+1 only.
- Back-to-back brackets: a second bracket may be accepted at N+1 when no branch was issued, and sees the updated stack.
- Simultaneous `op_out_ack` and a new datapath-op accept in the same cycle is legal. `op_out` is replaced with no bubble.
- Stack top+1 wraps modulo 2^PC_WIDTH.
- Reset asserted mid-skip or mid-branch: all state returns to reset values on the next edge; a pending `branch` is cancelled.

## Structure
- `Constants.v` additions:
  - opcode bit indices (`OP_LOOP_BEGIN`=6, `OP_LOOP_END`=7, others)
  - state encodings (RUN, SKIP, ERR)
  - existing `OPCODE_MSB`
- Sub-module `loop_stack`: parameterised LIFO with push, pop, top, full, empty, count. It exposes top combinationally and updates on the clock edge. `loop_controller` owns the FSM, skip counter, output register and branch register.

## Test plan
- `+ + > .` streamed with `op_out_ack`=1 → same four ops on `op_out` one cycle later, back-to-back; `op_ack` high every cycle.
- `[`@pc 5 with cell≠0, then `]`@pc 9 with cell≠0 → `loop_level` 1; `branch` pulse with `branch_target`=6; second `]` with cell=0 → `loop_level` 0, no branch.
- `[` with cell=0, then `[ + ] - ]` → nothing forwarded; RUN resumes after the final `]`; the next `>` is forwarded.
- `[` offered with `op_out_valid`=1 and `op_out_ack`=0 → `op_ack`=0 until drained and `cell_zero_valid`=1.
- 17 nested `[` (cell≠0) with `STACK_DEPTH`=16 → `error`=1 after the 17th, `op_ack` stuck 0; a lone `]` after reset (cell=0) also sets `error`.
- Reset asserted during SKIP at depth 3 → all outputs return to reset values; next `+` is forwarded normally.

Source files
------------

// File: rtl/loop_controller_pkg.sv
// loop_controller_pkg
// Shared constants for the brainfuck CPU control-flow stage: opcode bit
// positions of the one-hot operation word, the loop_controller state
// encoding, and a helper that flags malformed bracket opcodes.
package loop_controller_pkg;

    localparam int OPCODE_MSB    = 7;

    localparam int OP_RIGHT      = 0;   // >
    localparam int OP_LEFT       = 1;   // <
    localparam int OP_INC        = 2;   // +
    localparam int OP_DEC        = 3;   // -
    localparam int OP_OUTPUT     = 4;   // .
    localparam int OP_INPUT      = 5;   // ,
    localparam int OP_LOOP_BEGIN = 6;   // [
    localparam int OP_LOOP_END   = 7;   // ]

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SKIP = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // A bracket bit combined with any other bit is not a legal opcode.
    // op & (op - 1) clears the lowest set bit, so it is non-zero exactly
    // when more than one bit is set.
    function automatic logic is_malformed(input logic [OPCODE_MSB:0] op);
        logic [OPCODE_MSB:0] rest;
        rest = op & (op - {{OPCODE_MSB{1'b0}}, 1'b1});
        return (op[OP_LOOP_BEGIN] | op[OP_LOOP_END]) & (rest != '0);
    endfunction

endpackage

// File: rtl/loop_controller_stack.sv
// loop_stack
// Parameterised LIFO holding return addresses of open loops.
// Ports:
//   clk, reset       clock, synchronous active-high reset (clears occupancy)
//   push, push_data  write push_data on top (ignored when full)
//   pop              drop the top entry (ignored when empty)
//   top              current top entry, combinational
//   full, empty      occupancy flags
//   count            number of stored entries, 0..DEPTH
module loop_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] top_pos;

    assign top_pos = cnt - CNT_W'(1);
    assign top     = mem[top_pos[PTR_W-1:0]];
    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CNT_W'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Storage carries no reset; only the occupancy count defines validity.
    always_ff @(posedge clk) begin
        if (push && !full && !reset) begin
            mem[cnt[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/loop_controller.sv
// loop_controller
// Control-flow stage between instruction decode and the datapath. Forwards
// datapath ops through a one-entry output register and executes [ and ]
// locally using a return-address stack, a skip-depth counter and a
// one-cycle branch request to fetch.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   op_in, op_pc, op_valid        one-hot op from decode with its address
//   op_ack                        op consumed this cycle
//   cell_zero, cell_zero_valid    current cell == 0, final when valid
//   op_out, op_out_valid          forwarded datapath op
//   op_out_ack                    datapath accepts op_out
//   branch, branch_target         one-cycle redirect to fetch
//   error                         sticky fault, cleared only by reset
//   loop_level                    return-stack occupancy
module loop_controller
    import loop_controller_pkg::*;
#(
    parameter int PC_WIDTH    = 12,
    parameter int STACK_DEPTH = 16,
    parameter int SKIP_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [OPCODE_MSB:0]          op_in,
    input  logic [PC_WIDTH-1:0]          op_pc,
    input  logic                         op_valid,
    output logic                         op_ack,
    input  logic                         cell_zero,
    input  logic                         cell_zero_valid,
    output logic [OPCODE_MSB:0]          op_out,
    output logic                         op_out_valid,
    input  logic                         op_out_ack,
    output logic                         branch,
    output logic [PC_WIDTH-1:0]          branch_target,
    output logic                         error,
    output logic [$clog2(STACK_DEPTH):0] loop_level
);

    state_t                state, state_next;
    logic [SKIP_WIDTH-1:0] skip_depth, skip_next;
    logic [OPCODE_MSB:0]   out_next;
    logic                  out_valid_next;
    logic                  branch_next;
    logic [PC_WIDTH-1:0]   target_next;
    logic                  push, pop;
    logic [PC_WIDTH-1:0]   stk_top;
    logic                  stk_full, stk_empty;
    logic                  is_open, is_close, bad;

    assign is_open  = op_in[OP_LOOP_BEGIN];
    assign is_close = op_in[OP_LOOP_END];
    assign bad      = is_malformed(op_in);
    assign error    = (state == ST_ERR);

    loop_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (op_pc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .count     (loop_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        skip_next      = skip_depth;
        out_next       = op_out;
        out_valid_next = op_out_valid & ~op_out_ack;  // drains in every state
        branch_next    = 1'b0;
        target_next    = branch_target;
        push           = 1'b0;
        pop            = 1'b0;
        op_ack         = 1'b0;

        // Fetch/decode are flushing while branch is high, so nothing is taken.
        unique case (state)
            ST_RUN: begin
                if (op_valid && !branch) begin
                    if (bad) begin
                        op_ack     = 1'b1;
                        state_next = ST_ERR;
                    end else if (is_open || is_close) begin
                        // Brackets wait for the datapath to settle so that
                        // cell_zero reflects every op issued before them.
                        op_ack = cell_zero_valid & ~op_out_valid;
                        if (op_ack) begin
                            if (is_open) begin
                                if (cell_zero) begin
                                    skip_next  = SKIP_WIDTH'(1);
                                    state_next = ST_SKIP;
                                end else if (stk_full) begin
                                    state_next = ST_ERR;
                                end else begin
                                    push = 1'b1;
                                end
                            end else begin
                                if (stk_empty) begin
                                    state_next = ST_ERR;
                                end else if (!cell_zero) begin
                                    branch_next = 1'b1;
                                    target_next = stk_top + PC_WIDTH'(1);
                                end else begin
                                    pop = 1'b1;
                                end
                            end
                        end
                    end else begin
                        op_ack = ~op_out_valid | op_out_ack;
                        if (op_ack && (op_in != '0)) begin
                            out_next       = op_in;
                            out_valid_next = 1'b1;
                        end
                    end
                end
            end
            ST_SKIP: begin
                if (op_valid && !branch) begin
                    op_ack = 1'b1;
                    if (bad) begin
                        state_next = ST_ERR;
                    end else if (is_open) begin
                        if (&skip_depth) begin
                            state_next = ST_ERR;
                        end else begin
                            skip_next = skip_depth + SKIP_WIDTH'(1);
                        end
                    end else if (is_close) begin
                        skip_next = skip_depth - SKIP_WIDTH'(1);
                        if (skip_depth == SKIP_WIDTH'(1)) begin
                            state_next = ST_RUN;
                        end
                    end
                end
            end
            ST_ERR: begin
                state_next = ST_ERR;
            end
            default: begin
                state_next = ST_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skip_depth    <= '0;
            op_out        <= '0;
            op_out_valid  <= 1'b0;
            branch        <= 1'b0;
            branch_target <= '0;
        end else begin
            skip_depth    <= skip_next;
            op_out        <= out_next;
            op_out_valid  <= out_valid_next;
            branch        <= branch_next;
            branch_target <= target_next;
        end
    end

endmodule

// File: tb/tb_loop_controller.sv
module tb_loop_controller;

    localparam logic [7:0] R   = 8'h01;
    localparam logic [7:0] INC = 8'h04;
    localparam logic [7:0] DEC = 8'h08;
    localparam logic [7:0] OUT = 8'h10;
    localparam logic [7:0] LB  = 8'h40;
    localparam logic [7:0] LE  = 8'h80;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  op_in = '0;
    logic [11:0] op_pc = '0;
    logic        op_valid = 1'b0;
    logic        op_ack;
    logic        cell_zero = 1'b0;
    logic        cell_zero_valid = 1'b1;
    logic [7:0]  op_out;
    logic        op_out_valid;
    logic        op_out_ack = 1'b1;
    logic        branch;
    logic [11:0] branch_target;
    logic        error;
    logic [4:0]  loop_level;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [11:0] m_stk[$];
    int          m_mode;      // 0 running, 1 skipping, 2 faulted
    int          m_depth;
    logic [7:0]  m_out;
    bit          m_out_v;
    bit          m_br;
    logic [11:0] m_tgt;

    always #5 clk = ~clk;

    loop_controller #(
        .PC_WIDTH    (12),
        .STACK_DEPTH (16),
        .SKIP_WIDTH  (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .op_in           (op_in),
        .op_pc           (op_pc),
        .op_valid        (op_valid),
        .op_ack          (op_ack),
        .cell_zero       (cell_zero),
        .cell_zero_valid (cell_zero_valid),
        .op_out          (op_out),
        .op_out_valid    (op_out_valid),
        .op_out_ack      (op_out_ack),
        .branch          (branch),
        .branch_target   (branch_target),
        .error           (error),
        .loop_level      (loop_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(input logic [7:0] op);
        return (op[7] | op[6]) && ($countones(op) > 1);
    endfunction

    task automatic model_reset();
        m_stk.delete();
        m_mode  = 0;
        m_depth = 0;
        m_out   = '0;
        m_out_v = 0;
        m_br    = 0;
        m_tgt   = '0;
    endtask

    function automatic bit model_ack();
        if (!op_valid || m_mode == 2 || m_br) return 0;
        if (m_mode == 1 || is_bad(op_in)) return 1;
        if (op_in[6] || op_in[7]) return cell_zero_valid && !m_out_v;
        return !m_out_v || op_out_ack;
    endfunction

    task automatic model_step(input bit acc);
        bit br_n;
        br_n = 0;
        if (m_out_v && op_out_ack) m_out_v = 0;
        if (acc) begin
            if (is_bad(op_in)) begin
                m_mode = 2;
            end else if (m_mode == 1) begin
                if (op_in[6]) begin
                    if (m_depth == 255) m_mode = 2;
                    else m_depth++;
                end else if (op_in[7]) begin
                    m_depth--;
                    if (m_depth == 0) m_mode = 0;
                end
            end else if (op_in[6]) begin
                if (cell_zero) begin
                    m_depth = 1;
                    m_mode  = 1;
                end else if (m_stk.size() == 16) begin
                    m_mode = 2;
                end else begin
                    m_stk.push_back(op_pc);
                end
            end else if (op_in[7]) begin
                if (m_stk.size() == 0) begin
                    m_mode = 2;
                end else if (!cell_zero) begin
                    br_n  = 1;
                    m_tgt = m_stk[$] + 12'd1;
                end else begin
                    void'(m_stk.pop_back());
                end
            end else if (op_in != 8'h00) begin
                m_out   = op_in;
                m_out_v = 1;
            end
        end
        m_br = br_n;
    endtask

    task automatic check_outputs();
        chk("op_out", 32'(op_out), 32'(m_out));
        chk("op_out_valid", 32'(op_out_valid), 32'(m_out_v));
        chk("branch", 32'(branch), 32'(m_br));
        chk("branch_target", 32'(branch_target), 32'(m_tgt));
        chk("error", 32'(error), 32'(m_mode == 2));
        chk("loop_level", 32'(loop_level), 32'(m_stk.size()));
    endtask

    task automatic cyc(input bit v, input logic [7:0] op, input logic [11:0] pc,
                       input bit cz, input bit czv, input bit oack);
        bit ea;
        @(negedge clk);
        check_outputs();
        op_valid        = v;
        op_in           = op;
        op_pc           = pc;
        cell_zero       = cz;
        cell_zero_valid = czv;
        op_out_ack      = oack;
        #1;
        ea = model_ack();
        chk("op_ack", 32'(op_ack), 32'(ea));
        @(posedge clk);
        model_step(ea);
    endtask

    task automatic op1(input logic [7:0] op, input logic [11:0] pc, input bit cz);
        cyc(1, op, pc, cz, 1, 1);
    endtask

    task automatic idle();
        cyc(0, 8'h00, 12'h000, 0, 1, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        op_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check_outputs();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rop;
        int r;

        model_reset();
        do_reset();

        // Streaming datapath ops
        op1(INC, 12'd0, 0);
        op1(INC, 12'd1, 0);
        op1(R,   12'd2, 0);
        op1(OUT, 12'd3, 0);
        #1 chk("stream_last", 32'(op_out), 32'h10);
        idle();
        idle();

        // Loop taken once, then exited
        op1(LB, 12'd5, 0);
        op1(LE, 12'd9, 0);
        #1;
        chk("br_pulse", 32'(branch), 32'd1);
        chk("br_target6", 32'(branch_target), 32'd6);
        chk("br_level1", 32'(loop_level), 32'd1);
        cyc(1, INC, 12'd6, 0, 1, 1);   // offered during branch cycle: not taken
        op1(LE, 12'd9, 1);
        #1;
        chk("exit_level0", 32'(loop_level), 32'd0);
        chk("exit_nobr", 32'(branch), 32'd0);

        // Skipped loop body
        op1(LB,  12'd20, 1);
        op1(LB,  12'd21, 0);
        op1(INC, 12'd22, 0);
        op1(LE,  12'd23, 1);
        op1(DEC, 12'd24, 0);
        op1(LE,  12'd25, 1);
        #1 chk("skip_nofwd", 32'(op_out_valid), 32'd0);
        op1(R, 12'd26, 0);
        #1;
        chk("skip_resume_op", 32'(op_out), 32'h01);
        chk("skip_resume_v", 32'(op_out_valid), 32'd1);

        // Bracket stalled behind a pending output and an unsettled cell
        op1(INC, 12'd30, 0);
        cyc(1, LB, 12'd31, 0, 1, 0);
        cyc(1, LB, 12'd31, 0, 1, 0);
        cyc(1, LB, 12'd31, 0, 1, 0);
        cyc(1, LB, 12'd31, 0, 1, 1);
        cyc(1, LB, 12'd31, 0, 0, 1);
        cyc(1, LB, 12'd31, 0, 1, 1);
        #1 chk("stall_push", 32'(loop_level), 32'd1);

        // Stack overflow
        do_reset();
        for (int i = 0; i < 17; i++) op1(LB, 12'(i), 0);
        #1;
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_level", 32'(loop_level), 32'd16);
        op1(INC, 12'd17, 0);
        #1 chk("ovf_out", 32'(op_out_valid), 32'd0);

        // Close without open
        do_reset();
        op1(LE, 12'd0, 1);
        #1 chk("underflow_err", 32'(error), 32'd1);

        // Reset during skip at depth 3
        do_reset();
        op1(LB, 12'd1, 1);
        op1(LB, 12'd2, 0);
        op1(LB, 12'd3, 1);
        do_reset();
        op1(INC, 12'd0, 0);
        #1;
        chk("post_rst_op", 32'(op_out), 32'h04);
        chk("post_rst_v", 32'(op_out_valid), 32'd1);

        // Malformed opcode
        do_reset();
        op1(8'h41, 12'd0, 0);
        #1 chk("malformed_err", 32'(error), 32'd1);

        // Return address wraps
        do_reset();
        op1(LB, 12'hFFF, 0);
        op1(LE, 12'h100, 0);
        #1;
        chk("wrap_br", 32'(branch), 32'd1);
        chk("wrap_target", 32'(branch_target), 32'd0);

        // Skip depth saturation
        do_reset();
        op1(LB, 12'd0, 1);
        for (int i = 0; i < 254; i++) op1(LB, 12'd0, 0);
        #1 chk("skip255_ok", 32'(error), 32'd0);
        op1(LB, 12'd0, 0);
        #1 chk("skip_ovf_err", 32'(error), 32'd1);

        // Randomized segments
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                r = int'($urandom_range(0, 63));
                if (r == 0)       rop = 8'h81;
                else if (r < 12)  rop = LB;
                else if (r < 24)  rop = LE;
                else if (r < 28)  rop = 8'h00;
                else              rop = 8'h01 << $urandom_range(0, 5);
                cyc(($urandom % 4) != 0, rop, 12'($urandom),
                    ($urandom % 2) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0);
            end
        end
        @(negedge clk);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
